// File: rtl/relm_mul_pipe.sv
// Three-stage pipelined WD x WD -> 2*WD multiplier for the divide datapath.
// Define RELM_MUL_SIGNED_EN to honour sgn_in (two's-complement products).
module relm_mul_pipe #(
  parameter int WD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [WD-1:0]   a_in,
  input  logic [WD-1:0]   x_in,
  input  logic            sgn_in,
  input  logic            stall_in,
  output logic            valid_out,
  output logic [2*WD-1:0] ax_out
);

  localparam int HW = WD / 2;
  localparam int PW = 2 * WD;

  logic          v1;
  logic [WD-1:0] a1;
  logic [WD-1:0] x1;

  logic          v2;
  logic [WD-1:0] ll;
  logic [WD-1:0] lh;
  logic [WD-1:0] hl;
  logic [WD-1:0] hh;
  logic [WD-1:0] corr;

  logic [HW-1:0] ah;
  logic [HW-1:0] al;
  logic [HW-1:0] xh;
  logic [HW-1:0] xl;
  logic [PW-1:0] sum;

  function automatic logic [WD-1:0] half_mul(input logic [HW-1:0] p, input logic [HW-1:0] q);
    return {{HW{1'b0}}, p} * {{HW{1'b0}}, q};
  endfunction

  assign {ah, al} = a1;
  assign {xh, xl} = x1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      x1 <= '0;
    end else if (!stall_in) begin
      v1 <= valid_in;
      a1 <= a_in;
      x1 <= x_in;
    end
  end

`ifdef RELM_MUL_SIGNED_EN
  logic          s1;
  logic [WD-1:0] corr_d;

  // Signed product = unsigned product minus (sign-weighted other operand) << WD.
  always_comb begin
    corr_d = '0;
    if (s1 && a1[WD-1]) corr_d = corr_d + x1;
    if (s1 && x1[WD-1]) corr_d = corr_d + a1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      corr <= '0;
    end else if (!stall_in) begin
      s1   <= sgn_in;
      corr <= corr_d;
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn_in;
  assign corr       = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      ll <= '0;
      lh <= '0;
      hl <= '0;
      hh <= '0;
    end else if (!stall_in) begin
      v2 <= v1;
      ll <= half_mul(al, xl);
      lh <= half_mul(al, xh);
      hl <= half_mul(ah, xl);
      hh <= half_mul(ah, xh);
    end
  end

  // Modulo 2^(2*WD) arithmetic gives the same low bits as a 2*WD+1 wide sum.
  always_comb begin
    sum = (PW'(hh) << WD) + ((PW'(lh) + PW'(hl)) << HW) + PW'(ll) - (PW'(corr) << WD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      ax_out    <= '0;
    end else if (!stall_in) begin
      valid_out <= v2;
      ax_out    <= sum;
    end
  end

endmodule

// File: tb/tb_relm_mul_pipe.sv
// Directed self-checking bench for relm_mul_pipe (WD=32); expectations follow
// whether RELM_MUL_SIGNED_EN is defined for the build.
module tb_relm_mul_pipe;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] a_in;
  logic [31:0] x_in;
  logic        sgn_in;
  logic        stall_in;
  logic        valid_out;
  logic [63:0] ax_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] stream_exp [8] = '{64'h0, 64'h20000, 64'h60000, 64'hC0000,
                                  64'h140000, 64'h1E0000, 64'h2A0000, 64'h380000};
  logic        bub_v [20];
  logic [63:0] bub_p [20];

  relm_mul_pipe #(.WD(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a_in      (a_in),
    .x_in      (x_in),
    .sgn_in    (sgn_in),
    .stall_in  (stall_in),
    .valid_out (valid_out),
    .ax_out    (ax_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] x,
                               input logic s, input logic st);
    valid_in = v;
    a_in     = a;
    x_in     = x;
    sgn_in   = s;
    stall_in = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Reference product, written independently of the partial-product scheme.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] x, input logic s);
    logic [63:0] r;
    r = {32'h0, a} * {32'h0, x};
`ifdef RELM_MUL_SIGNED_EN
    if (s) r = $signed({{32{a[31]}}, a}) * $signed({{32{x[31]}}, x});
`else
    if (s) r = {32'h0, a} * {32'h0, x};
`endif
    return r;
  endfunction

  initial begin
    logic [63:0] exp_neg1;
    logic [63:0] exp_min2;
    logic        bv;
    logic [31:0] ba;
    logic [31:0] bx;
    logic        bs;

`ifdef RELM_MUL_SIGNED_EN
    exp_neg1 = 64'h00000000_00000001;
    exp_min2 = 64'hFFFFFFFF_00000000;
`else
    exp_neg1 = 64'hFFFFFFFE_00000001;
    exp_min2 = 64'h00000001_00000000;
`endif

    rst = 1'b1; valid_in = 1'b0; a_in = '0; x_in = '0; sgn_in = 1'b0; stall_in = 1'b0;
    #2;
    checkOutput("reset_valid", {63'h0, valid_out}, 64'h0);
    checkOutput("reset_ax", ax_out, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Unsigned corner, exact three-edge latency
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("ucorner_lat1", {63'h0, valid_out}, 64'h0);
    idle();
    checkOutput("ucorner_lat2", {63'h0, valid_out}, 64'h0);
    idle();
    checkOutput("ucorner_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("ucorner_ax", ax_out, 64'hFFFFFFFE_00000001);

    // Signed requests back to back
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'h00000002, 1'b1, 1'b0);
    idle();
    checkOutput("signed_neg1_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("signed_neg1_ax", ax_out, exp_neg1);
    idle();
    checkOutput("signed_min2_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("signed_min2_ax", ax_out, exp_min2);

    // Streaming: 8 back-to-back issues
    for (int c = 0; c < 11; c++) begin
      applyStimulus(c < 8, 32'(c + 1), 32'(c * 32'h10000), 1'b0, 1'b0);
      if (c < 2 || c == 10) begin
        checkOutput($sformatf("stream_idle_%0d", c), {63'h0, valid_out}, 64'h0);
      end else begin
        checkOutput($sformatf("stream_valid_%0d", c - 2), {63'h0, valid_out}, 64'h1);
        checkOutput($sformatf("stream_ax_%0d", c - 2), ax_out, stream_exp[c - 2]);
      end
    end

    // Stall from a known reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    applyStimulus(1'b1, 32'h00000003, 32'hFFFFFFFD, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(c == 1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
      checkOutput($sformatf("stall_hold_valid_%0d", c), {63'h0, valid_out}, 64'h0);
      checkOutput($sformatf("stall_hold_ax_%0d", c), ax_out, 64'h0);
    end
    idle();
    checkOutput("stall_not_early", {63'h0, valid_out}, 64'h0);
    idle();
    checkOutput("stall_result_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("stall_result_ax", ax_out, 64'h00000002_FFFFFFF7);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(c == 0, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1);
      checkOutput($sformatf("stall_keep_valid_%0d", c), {63'h0, valid_out}, 64'h1);
      checkOutput($sformatf("stall_keep_ax_%0d", c), ax_out, 64'h00000002_FFFFFFF7);
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      checkOutput($sformatf("stall_dropped_%0d", c), {63'h0, valid_out}, 64'h0);
    end

    // Bubbles: alternate issues with random operands
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        bv = (c % 2 == 0);
        ba = $urandom;
        bx = $urandom;
        bs = 1'($urandom_range(0, 1));
        bub_v[c] = bv;
        bub_p[c] = model(ba, bx, bs);
        applyStimulus(bv, ba, bx, bs, 1'b0);
      end else begin
        idle();
      end
      if (c >= 2) begin
        checkOutput($sformatf("bubble_valid_%0d", c - 2), {63'h0, valid_out}, {63'h0, bub_v[c - 2]});
        if (bub_v[c - 2]) checkOutput($sformatf("bubble_ax_%0d", c - 2), ax_out, bub_p[c - 2]);
      end
    end

    // Asynchronous reset with three operations in flight
    applyStimulus(1'b1, 32'h00000007, 32'h00000009, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000011, 32'h00000013, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000100, 32'h00000100, 1'b0, 1'b0);
    checkOutput("flight_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("flight_ax", ax_out, 64'h3F);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {63'h0, valid_out}, 64'h0);
    checkOutput("async_rst_ax", ax_out, 64'h0);
    applyStimulus(1'b1, 32'h00000005, 32'h00000005, 1'b0, 1'b0);
    checkOutput("rst_ignores_valid", {63'h0, valid_out}, 64'h0);
    #3 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle();
      checkOutput($sformatf("post_rst_valid_%0d", c), {63'h0, valid_out}, 64'h0);
      checkOutput($sformatf("post_rst_ax_%0d", c), ax_out, 64'h0);
    end
    applyStimulus(1'b1, 32'h0000000B, 32'h0000000D, 1'b0, 1'b0);
    idle();
    idle();
    checkOutput("post_rst_new_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("post_rst_new_ax", ax_out, 64'h8F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
